// File: rtl/tape_fetch.sv
// Tape-port prefetcher: streams a byte region from the SDRAM tape port into a small FIFO.
// Optional looping playback is enabled by defining TAPE_FETCH_WRAP_EN.
module tape_fetch #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] tape_addr,
  output logic              tape_rd,
  input  logic              tape_rd_ack,
  input  logic [7:0]        tape_dout,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_ABORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [ADDR_W-1:0] taddr_q, taddr_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              ack_seen_q, ack_seen_d;
  logic              ack_loaded_q;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              ack_hit;
  logic              push, pop, flush;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;

`ifdef TAPE_FETCH_WRAP_EN
  logic [ADDR_W-1:0] base_addr_q;
  logic [ADDR_W-1:0] base_len_q;
`endif

  assign ack_hit    = (tape_rd_ack != ack_seen_q);
  assign byte_valid = (count_q != '0);
  assign pop        = byte_valid && byte_ready;
  assign byte_data  = mem[rd_ptr];
  assign busy       = (state_q != S_IDLE);
  assign tape_addr  = taddr_q;
  assign tape_rd    = rd_q;
  assign done       = done_q;
  assign error      = error_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    ack_seen_d = ack_loaded_q ? ack_seen_q : tape_rd_ack;
    tmo_d      = tmo_q;
    error_d    = error_q;
    done_d     = 1'b0;
    rd_d       = 1'b0;
    taddr_d    = taddr_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (length != '0) begin
            addr_d   = start_addr;
            remain_d = length;
            state_d  = S_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (stop) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (count_q < DEPTH_C) begin
          rd_d    = 1'b1;
          taddr_d = addr_q;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // ack_seen is left alone on stop so ABORT still sees the pending ack
        if (stop) begin
          flush   = 1'b1;
          state_d = S_ABORT;
        end else if (ack_hit) begin
          push       = 1'b1;
          ack_seen_d = tape_rd_ack;
          addr_d     = addr_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          if (remain_q == ADDR_W'(1)) begin
`ifdef TAPE_FETCH_WRAP_EN
            addr_d   = base_addr_q;
            remain_d = base_len_q;
            state_d  = S_REQ;
`else
            state_d  = S_DRAIN;
`endif
          end else begin
            state_d = S_REQ;
          end
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          flush   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // done is raised while still in DRAIN; busy falls on the following cycle
        if (stop) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (count_q == '0) begin
          if (done_q) state_d = S_IDLE;
          else        done_d  = 1'b1;
        end
      end
      S_ABORT: begin
        if (ack_hit) begin
          ack_seen_d = tape_rd_ack;
          state_d    = S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      taddr_q      <= '0;
      tmo_q        <= '0;
      ack_seen_q   <= 1'b0;
      ack_loaded_q <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      taddr_q      <= taddr_d;
      tmo_q        <= tmo_d;
      ack_seen_q   <= ack_seen_d;
      ack_loaded_q <= 1'b1;
      error_q      <= error_d;
      done_q       <= done_d;
      rd_q         <= rd_d;
    end
  end

`ifdef TAPE_FETCH_WRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_addr_q <= '0;
      base_len_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      base_addr_q <= start_addr;
      base_len_q  <= length;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem     <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= tape_dout;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_tape_fetch.sv
// Self-checking bench for tape_fetch: table-driven runs, random runs and corner sequences
// against a byte-region reference model and a behavioural tape memory responder.
module tb_tape_fetch;
  localparam int unsigned ADDR_W     = 23;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 255;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic [ADDR_W-1:0] tape_addr;
  logic              tape_rd;
  logic              tape_rd_ack = 1'b0;
  logic [7:0]        tape_dout = '0;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready = 1'b1;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  tape_fetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .start_addr(start_addr), .length(length), .tape_addr(tape_addr),
    .tape_rd(tape_rd), .tape_rd_ack(tape_rd_ack), .tape_dout(tape_dout),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .error(error)
  );

  int vectors = 0;
  int miscompares = 0;
  int ack_delay = 1;
  bit resp_en = 1'b1;
  bit rand_ready = 1'b0;
  logic [ADDR_W-1:0] rd_log[$];
  logic [7:0]        got[$];
  int   done_cnt = 0;
  logic busy_at_done = 1'b0;
  logic busy_after_done = 1'b1;
  bit   chk_next = 1'b0;
  logic [ADDR_W-1:0] ra;

  // tape memory contents: base 0x100 holds 0x11, 0x12, ...
  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    return a[7:0] + 8'h10 + a[15:8] + {1'b0, a[22:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got_v, exp_v);
    end
  endtask

  // memory responder: one ack toggle ack_delay cycles after each read pulse
  initial begin
    forever begin
      @(negedge clk);
      if (tape_rd === 1'b1 && resp_en) begin
        ra = tape_addr;
        repeat (ack_delay) @(posedge clk);
        #1;
        tape_dout   = mem_byte(ra);
        tape_rd_ack = ~tape_rd_ack;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tape_rd === 1'b1) rd_log.push_back(tape_addr);
      if (done === 1'b1) begin
        done_cnt++;
        busy_at_done = busy;
        chk_next = 1'b1;
      end else if (chk_next) begin
        busy_after_done = busy;
        chk_next = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) byte_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (byte_valid === 1'b1 && byte_ready) got.push_back(byte_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_run(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] len);
    rd_log.delete();
    got.delete();
    done_cnt = 0;
    busy_at_done = 1'b0;
    busy_after_done = 1'b1;
    @(posedge clk); #1;
    start_addr = sa;
    length = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int c;
    for (c = 0; c < limit; c++) begin
      @(negedge clk);
      if (c >= 2 && !busy && !byte_valid) break;
    end
    chk({name, "_idle_timeout"}, 32'(c >= limit), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // reference model: n reads at sa, sa+1, ... (mod 2^ADDR_W), delivering mem_byte in order
  task automatic chk_run(input string name, input logic [ADDR_W-1:0] sa, input int n);
    int bad_a;
    int bad_d;
    logic [ADDR_W-1:0] ea;
    bad_a = -1;
    bad_d = -1;
    for (int i = 0; i < n; i++) begin
      ea = sa + ADDR_W'(i);
      if (bad_a < 0 && (i >= rd_log.size() || rd_log[i] !== ea)) bad_a = i;
      if (bad_d < 0 && (i >= got.size() || got[i] !== mem_byte(ea))) bad_d = i;
    end
    chk({name, "_nreads"}, 32'(rd_log.size()), 32'(n));
    chk({name, "_nbytes"}, 32'(got.size()), 32'(n));
    chk({name, "_addr_err_idx"}, 32'(bad_a), 32'hFFFF_FFFF);
    chk({name, "_data_err_idx"}, 32'(bad_d), 32'hFFFF_FFFF);
  endtask

  task automatic run_one(input string name, input logic [ADDR_W-1:0] sa,
                         input logic [ADDR_W-1:0] len, input int dly, input bit rmode,
                         input int exp_reads, input int exp_done);
    ack_delay = dly;
    rand_ready = rmode;
    if (!rmode) byte_ready = 1'b1;
    start_run(sa, len);
    wait_idle(name, 2000);
    rand_ready = 1'b0;
    byte_ready = 1'b1;
    chk_run(name, sa, exp_reads);
    chk({name, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({name, "_error"}, 32'(error), 32'd0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] len;
    int                dly;
    bit                rmode;
    int                exp_reads;
    int                exp_done;
  } run_t;

  run_t tbl[6];

  initial begin
    int lat;
    int cnt;
    int bad;
    tbl[0] = '{sa: 23'h000100, len: 23'd5, dly: 1, rmode: 1'b0, exp_reads: 5, exp_done: 1};
    tbl[1] = '{sa: 23'h7FFFFE, len: 23'd4, dly: 2, rmode: 1'b1, exp_reads: 4, exp_done: 1};
    tbl[2] = '{sa: 23'h000000, len: 23'd0, dly: 1, rmode: 1'b0, exp_reads: 0, exp_done: 1};
    tbl[3] = '{sa: 23'h012345, len: 23'd1, dly: 1, rmode: 1'b0, exp_reads: 1, exp_done: 1};
    tbl[4] = '{sa: 23'h000040, len: 23'd9, dly: 3, rmode: 1'b1, exp_reads: 9, exp_done: 1};
    tbl[5] = '{sa: 23'h3ABCDE, len: 23'd6, dly: 1, rmode: 1'b1, exp_reads: 6, exp_done: 1};

    // reset state, checked while reset is still asserted
    #1;
    chk("rst_ctl", 32'({tape_rd, busy, done, error, byte_valid}), 32'd0);
    chk("rst_tape_addr", 32'(tape_addr), 32'd0);
    chk("rst_byte_data", 32'(byte_data), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'({tape_rd, busy, done, error, byte_valid}), 32'd0);

`ifdef TAPE_FETCH_WRAP_EN
    ack_delay = 1;
    byte_ready = 1'b1;
    start_run(23'h000600, 23'd3);
    for (int c = 0; c < 200 && rd_log.size() < 6; c++) @(negedge clk);
    @(posedge clk); #1; stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_idle("wrap", 600);
    bad = -1;
    for (int i = 0; i < 5; i++) begin
      logic [ADDR_W-1:0] ea;
      ea = 23'h000600 + ADDR_W'(i % 3);
      if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== ea)) bad = i;
      if (bad < 0 && i < 4 && (i >= got.size() || got[i] !== mem_byte(ea))) bad = i;
    end
    chk("wrap_stream_err_idx", 32'(bad), 32'hFFFF_FFFF);
    chk("wrap_no_done", 32'(done_cnt), 32'd0);
`else
    // basic run with first-byte latency and done/busy shape
    ack_delay = 1;
    byte_ready = 1'b1;
    start_run(23'h000100, 23'd5);
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (byte_valid) break;
      lat++;
    end
    chk("basic_latency", 32'(lat), 32'd3);
    wait_idle("basic", 500);
    chk_run("basic", 23'h000100, 5);
    chk("basic_done", 32'(done_cnt), 32'd1);
    chk("basic_busy_at_done", 32'(busy_at_done), 32'd1);
    chk("basic_busy_after_done", 32'(busy_after_done), 32'd0);

    // zero length
    start_run(23'h000055, 23'd0);
    @(negedge clk);
    chk("zero_done", 32'({done, busy}), 32'b10);
    @(negedge clk);
    chk("zero_done_pulse", 32'({done, busy}), 32'b00);
    repeat (5) @(negedge clk);
    chk("zero_no_reads", 32'(rd_log.size()), 32'd0);

    // backpressure: FIFO fills, requests stall, head byte holds
    byte_ready = 1'b0;
    start_run(23'h000200, 23'd8);
    repeat (40) @(negedge clk);
    chk("bp_reads_stalled", 32'(rd_log.size()), 32'(FIFO_DEPTH));
    chk("bp_valid", 32'(byte_valid), 32'd1);
    chk("bp_head", 32'(byte_data), 32'(mem_byte(23'h000200)));
    repeat (3) @(negedge clk);
    chk("bp_head_stable", 32'(byte_data), 32'(mem_byte(23'h000200)));
    @(posedge clk); #1; byte_ready = 1'b1;
    wait_idle("bp", 500);
    chk_run("bp", 23'h000200, 8);
    chk("bp_done", 32'(done_cnt), 32'd1);

    // ack timeout
    resp_en = 1'b0;
    start_run(23'h000300, 23'd3);
    for (int c = 0; c < 10 && !tape_rd; c++) @(negedge clk);
    if (!tape_rd) @(negedge clk);
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      cnt++;
      if (error) break;
    end
    chk("tmo_cycles", 32'(cnt), 32'(TIMEOUT));
    repeat (4) @(negedge clk);
    chk("tmo_state", 32'({busy, byte_valid, error}), 32'b001);
    chk("tmo_no_done", 32'(done_cnt), 32'd0);
    resp_en = 1'b1;
    start_run(23'h000310, 23'd2);
    @(negedge clk);
    chk("tmo_err_cleared", 32'(error), 32'd0);
    wait_idle("tmo_rerun", 500);
    chk_run("tmo_rerun", 23'h000310, 2);

    // stop while waiting; the late ack must be absorbed
    ack_delay = 3;
    start_run(23'h000400, 23'd4);
    for (int c = 0; c < 10 && !tape_rd; c++) @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1; stop = 1'b0;
    wait_idle("stop", 500);
    chk("stop_bytes", 32'(got.size()), 32'd0);
    chk("stop_state", 32'({busy, byte_valid, done, error}), 32'd0);
    chk("stop_no_done", 32'(done_cnt), 32'd0);
    chk("stop_reads", 32'(rd_log.size()), 32'd1);
    run_one("stop_rerun", 23'h000500, 23'd2, 1, 1'b0, 2, 1);

    // asynchronous reset mid-stream
    ack_delay = 1;
    byte_ready = 1'b0;
    start_run(23'h000700, 23'd10);
    repeat (12) @(negedge clk);
    chk("arst_pre_active", 32'({busy, byte_valid, tape_addr != '0}), 32'b111);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ctl", 32'({tape_rd, busy, done, error, byte_valid}), 32'd0);
    chk("arst_tape_addr", 32'(tape_addr), 32'd0);
    chk("arst_byte_data", 32'(byte_data), 32'd0);
    repeat (6) @(negedge clk);
    reset_n = 1'b1;
    byte_ready = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].sa, tbl[i].len, tbl[i].dly, tbl[i].rmode,
              tbl[i].exp_reads, tbl[i].exp_done);

    for (int i = 0; i < 20; i++) begin
      logic [ADDR_W-1:0] rsa;
      int rlen;
      rsa  = ADDR_W'($urandom);
      rlen = int'($urandom_range(1, 12));
      run_one($sformatf("rnd%0d", i), rsa, ADDR_W'(rlen), int'($urandom_range(1, 4)),
              ($urandom_range(0, 1) == 1), rlen, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
